wkram_streamer: RTL and testbench
=================================

WKRAM_STREAMER -- requirements
Module: wkram_streamer

Interface
REQ-001 Parameter RAMSIZE, default 7'd47: number of payload bytes read from the work-RAM read port, range 1..127.
REQ-002 Parameter HDR_BYTE, default 8'hA5: frame start marker.
REQ-003 i_CLK  input  1  system clock; all logic is on its rising edge.
REQ-004 i_RST_n  input  1  reset, synchronous, active-low.
REQ-005 i_START  input  1  frame request, level-sampled in IDLE only.
REQ-006 o_BUSY  output  1  high from the cycle after an accepted start until DONE completes.
REQ-007 o_R2_RD  output  1  read enable to the work-RAM read port.
REQ-008 o_R2_RD_INDEX  output  7  read address to the work-RAM read port.
REQ-009 i_R2_OUT_DATA  input  8  registered read data; valid one cycle after o_R2_RD is high with a stable index.
REQ-010 o_TX_DATA  output  8  outgoing byte.
REQ-011 o_TX_VALID  output  1  byte-valid qualifier.
REQ-012 i_TX_READY  input  1  sink accept.
REQ-013 o_DONE  output  1  one-cycle pulse when the last byte of a frame has transferred.

Function
REQ-014 The frame is HDR_BYTE, LEN (=RAMSIZE), payload[0..RAMSIZE-1] read from indices 0..RAMSIZE-1 in order, then CHK, giving RAMSIZE+3 bytes in total.
REQ-015 CHK is chosen so that (LEN + all payload bytes + CHK) mod 256 == 0; the accumulator is 8 bits wide and wraps.
REQ-016 FSM states:
- IDLE -> HDR on i_START=1.
- HDR -> LEN on transfer.
- LEN -> RD_ADDR on transfer.
- RD_ADDR -> RD_WAIT after 1 cycle.
- RD_WAIT -> PAYLOAD after 1 cycle.
- PAYLOAD -> RD_ADDR on transfer if index < RAMSIZE-1; otherwise SUM.
- SUM -> DONE on transfer.
- DONE -> IDLE after 1 cycle.
REQ-017 A transfer occurs in a cycle where o_TX_VALID and i_TX_READY are both high; o_TX_VALID is high only in HDR, LEN, PAYLOAD and SUM.
REQ-018 While o_TX_VALID=1 and i_TX_READY=0, o_TX_DATA and o_TX_VALID hold unchanged.
REQ-019 In PAYLOAD, o_TX_DATA is the i_R2_OUT_DATA value captured on entry to PAYLOAD, held in a local register so it is immune to later read-port changes.
REQ-020 o_R2_RD rises on entry to RD_ADDR for index 0 and stays high continuously through SUM entry, so the upstream bank swap cannot occur mid-frame; it is low in IDLE, HDR, LEN, SUM and DONE.
REQ-021 o_R2_RD_INDEX is 0 in IDLE, holds stable from RD_ADDR through the PAYLOAD transfer, and increments by 1 on each PAYLOAD transfer.
REQ-022 The checksum accumulator clears in IDLE and adds LEN on the LEN transfer and each payload byte on its transfer; o_TX_DATA in SUM is its two's complement.
REQ-023 i_START is ignored while not in IDLE; if i_START is held high through DONE, a new frame starts on the cycle after returning to IDLE.
REQ-024 o_DONE is high exactly in the DONE cycle; o_BUSY is low only in IDLE.
REQ-025 With i_TX_READY held high, the minimum frame length from i_START to o_DONE is 2 + 3*RAMSIZE + 2 cycles.

Reset
REQ-026 On i_RST_n=0 at a clock edge, the block enters IDLE with o_BUSY=0, o_R2_RD=0, o_R2_RD_INDEX=0, o_TX_DATA=0, o_TX_VALID=0, o_DONE=0 and the checksum cleared.
REQ-027 Reset asserted mid-frame abandons the frame immediately: no o_DONE and no further bytes.

Structure
REQ-028 The FSM state enum, the HDR_BYTE default and the frame-overhead constant (3) live in a shared package, wkram_pkg.
REQ-029 The block is a single module with no sub-module; the checksum is inline logic.

Verification
REQ-030 RAM[i]=i, RAMSIZE=47, ready always high -> bytes A5, 2F, 00..2E, 98; o_DONE one pulse; o_R2_RD high for the whole read span.
REQ-031 All-zero RAM -> A5, 2F, 47x00, D1.
REQ-032 Pseudo-random i_TX_READY stalls -> byte sequence identical to REQ-030; o_TX_DATA stable during every stall; no index skip or repeat.
REQ-033 i_START pulsed while busy -> ignored; exactly one frame emitted.
REQ-034 i_RST_n=0 after payload byte 10 -> next cycle o_TX_VALID=0, o_R2_RD=0, index=0, no o_DONE; a subsequent i_START produces a full correct frame.
REQ-035 Upstream copy request issued mid-frame with the real upstream RAM model -> no bank swap until o_R2_RD falls; every payload byte comes from the pre-swap bank.

Source files
------------

// File: rtl/wkram_streamer_pkg.sv
// ---------------------------------------------------------------------------
// wkram_pkg
// Shared definitions for the work-RAM frame streamer.
//   state_e        : frame-sequencer states
//   HDR_BYTE_DEF   : default frame start marker
//   FRAME_OVERHEAD : non-payload bytes per frame (header, length, checksum)
//   twos_neg()     : checksum closing byte from the running 8-bit sum
// ---------------------------------------------------------------------------
package wkram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LEN,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_PAYLOAD,
    ST_SUM,
    ST_DONE
  } state_e;

  localparam logic [7:0] HDR_BYTE_DEF   = 8'hA5;
  localparam int         FRAME_OVERHEAD = 3;

  // Byte that brings (LEN + payload + CHK) to zero modulo 256.
  function automatic logic [7:0] twos_neg(input logic [7:0] acc);
    return 8'(~acc + 8'd1);
  endfunction

endpackage

// File: rtl/wkram_streamer_if.sv
// ---------------------------------------------------------------------------
// wkram_streamer_if
// Bundles the work-RAM read port and the outgoing byte stream.
//   o_R2_RD         : read enable to the work-RAM read port
//   o_R2_RD_INDEX   : read address (7 bits)
//   i_R2_OUT_DATA   : registered read data, valid one cycle after the read
//   o_TX_DATA       : outgoing byte
//   o_TX_VALID      : outgoing byte qualifier
//   i_TX_READY      : sink accept
// master = the streamer, slave = RAM / sink side.
// ---------------------------------------------------------------------------
interface wkram_streamer_if;
  logic       o_R2_RD;
  logic [6:0] o_R2_RD_INDEX;
  logic [7:0] i_R2_OUT_DATA;
  logic [7:0] o_TX_DATA;
  logic       o_TX_VALID;
  logic       i_TX_READY;

  modport master (
    output o_R2_RD, o_R2_RD_INDEX, o_TX_DATA, o_TX_VALID,
    input  i_R2_OUT_DATA, i_TX_READY
  );

  modport slave (
    input  o_R2_RD, o_R2_RD_INDEX, o_TX_DATA, o_TX_VALID,
    output i_R2_OUT_DATA, i_TX_READY
  );
endinterface

// File: rtl/wkram_streamer.sv
// ---------------------------------------------------------------------------
// wkram_streamer
// Reads RAMSIZE bytes from the work-RAM read port and sends them as a frame:
//   HDR_BYTE, LEN(=RAMSIZE), payload[0..RAMSIZE-1], CHK
// where CHK makes (LEN + payload + CHK) mod 256 == 0.
// Ports:
//   i_CLK    : clock, rising edge
//   i_RST_n  : synchronous active-low reset
//   i_START  : frame request, sampled only in IDLE
//   o_BUSY   : high whenever not IDLE
//   o_DONE   : one-cycle pulse after the last byte transferred
//   bus      : read port + byte stream (wkram_streamer_if.master)
// All outputs are registered.
// ---------------------------------------------------------------------------
module wkram_streamer
  import wkram_pkg::*;
#(
  parameter logic [6:0] RAMSIZE  = 7'd47,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
  input  logic             i_CLK,
  input  logic             i_RST_n,
  input  logic             i_START,
  output logic             o_BUSY,
  output logic             o_DONE,
  wkram_streamer_if.master bus
);

  state_e     state_q;
  logic       busy_q;
  logic       rd_q;
  logic [6:0] idx_q;
  logic [7:0] tx_data_q;
  logic       tx_valid_q;
  logic       done_q;
  logic [7:0] csum_q;

  logic       xfer;
  logic       more_d;
  logic [7:0] csum_d;
  logic [6:0] idx_d;

  // While a byte is offered, tx_data_q holds exactly the byte on the wire,
  // so the running sum can always add tx_data_q on a transfer.
  always_comb begin
    xfer   = tx_valid_q & bus.i_TX_READY;
    csum_d = csum_q + tx_data_q;
    idx_d  = idx_q + 7'd1;
    more_d = (idx_q < (RAMSIZE - 7'd1));
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      rd_q       <= 1'b0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      csum_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          csum_q <= '0;
          idx_q  <= '0;
          if (i_START) begin
            state_q    <= ST_HDR;
            busy_q     <= 1'b1;
            tx_valid_q <= 1'b1;
            tx_data_q  <= HDR_BYTE;
          end
        end
        ST_HDR: begin
          if (xfer) begin
            state_q   <= ST_LEN;
            tx_data_q <= {1'b0, RAMSIZE};
          end
        end
        ST_LEN: begin
          // Read enable rises here and stays up for the whole read span so
          // the upstream bank cannot swap under an open frame.
          if (xfer) begin
            state_q    <= ST_RD_ADDR;
            tx_valid_q <= 1'b0;
            rd_q       <= 1'b1;
            csum_q     <= csum_d;
          end
        end
        ST_RD_ADDR: begin
          state_q <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          // Capture the read data once; later read-port changes are ignored.
          state_q    <= ST_PAYLOAD;
          tx_valid_q <= 1'b1;
          tx_data_q  <= bus.i_R2_OUT_DATA;
        end
        ST_PAYLOAD: begin
          if (xfer) begin
            csum_q <= csum_d;
            idx_q  <= idx_d;
            if (more_d) begin
              state_q    <= ST_RD_ADDR;
              tx_valid_q <= 1'b0;
            end else begin
              state_q   <= ST_SUM;
              rd_q      <= 1'b0;
              tx_data_q <= twos_neg(csum_d);
            end
          end
        end
        ST_SUM: begin
          if (xfer) begin
            state_q    <= ST_DONE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            done_q     <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          idx_q   <= '0;
          csum_q  <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_BUSY            = busy_q;
  assign o_DONE            = done_q;
  assign bus.o_R2_RD       = rd_q;
  assign bus.o_R2_RD_INDEX = idx_q;
  assign bus.o_TX_DATA     = tx_data_q;
  assign bus.o_TX_VALID    = tx_valid_q;

endmodule

// File: tb/tb_wkram_streamer.sv
// ---------------------------------------------------------------------------
// tb_wkram_streamer
// Directed bench for wkram_streamer with a two-bank upstream RAM model
// (registered read, bank swap deferred while the read enable is high).
// ---------------------------------------------------------------------------
module tb_wkram_streamer;
  import wkram_pkg::*;

  localparam int N      = 47;
  localparam int FRAMEB = N + FRAME_OVERHEAD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  wkram_streamer_if bus ();

  wkram_streamer #(.RAMSIZE(7'd47), .HDR_BYTE(8'hA5)) dut (
    .i_CLK   (clk),
    .i_RST_n (rst_n),
    .i_START (start),
    .o_BUSY  (busy),
    .o_DONE  (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // upstream RAM model
  logic [7:0] mem_a [128];
  logic [7:0] mem_b [128];
  logic       bank_q    = 1'b0;
  logic       swap_pend = 1'b0;
  logic       copy_req  = 1'b0;
  int         swap_cyc  = -1;
  int         cyc       = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_R2_RD)
      bus.i_R2_OUT_DATA <= bank_q ? mem_b[bus.o_R2_RD_INDEX] : mem_a[bus.o_R2_RD_INDEX];
    if (swap_pend && !bus.o_R2_RD) begin
      bank_q    <= ~bank_q;
      swap_pend <= 1'b0;
      swap_cyc  <= cyc;
    end else if (copy_req) begin
      swap_pend <= 1'b1;
    end
  end

  // monitor (negedge, away from the active edge)
  logic [7:0] rx_d [1024];
  logic [6:0] rx_i [1024];
  logic       rx_r [1024];
  int   rx_n = 0, done_n = 0, done_cyc = 0, stall_bad = 0, rd_rise = 0;
  logic pstall = 1'b0, prd = 1'b0;
  logic [7:0] pdata = 8'h00;

  always @(negedge clk) begin
    if (pstall && (bus.o_TX_VALID !== 1'b1 || bus.o_TX_DATA !== pdata)) stall_bad++;
    pstall = bus.o_TX_VALID && !bus.i_TX_READY;
    pdata  = bus.o_TX_DATA;
    if (bus.o_TX_VALID === 1'b1 && bus.i_TX_READY === 1'b1 && rx_n < 1024) begin
      rx_d[rx_n] = bus.o_TX_DATA;
      rx_i[rx_n] = bus.o_R2_RD_INDEX;
      rx_r[rx_n] = bus.o_R2_RD;
      rx_n++;
    end
    if (bus.o_R2_RD === 1'b1 && !prd) rd_rise++;
    prd = bus.o_R2_RD;
    if (done === 1'b1) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit rnd, input bit poke, output int lat);
    int  base_done;
    int  t0;
    bit  ok;
    base_done = done_n;
    ok = 1'b0;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (rnd) bus.i_TX_READY = ($urandom_range(0, 2) != 0);
      if (poke) start = (k < 100) && (k % 7 == 3);
      tick();
      if (done_n != base_done) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    bus.i_TX_READY = 1'b1;
    lat = done_cyc - t0;
    chk("done_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_rx(input int target);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (rx_n >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_rx", 32'(ok), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [7:0] exp_chk);
    int bad_b, bad_i;
    logic [7:0] acc;
    bad_b = 0;
    bad_i = 0;
    acc = 8'h2F;
    chk({tag, "_count"}, 32'(rx_n - base), 32'(FRAMEB));
    chk({tag, "_hdr"}, 32'(rx_d[base]), 32'h A5);
    chk({tag, "_len"}, 32'(rx_d[base + 1]), 32'h2F);
    for (int k = 0; k < N; k++) begin
      if (rx_d[base + 2 + k] !== mem_a[k]) bad_b++;
      if (rx_i[base + 2 + k] !== 7'(k) || rx_r[base + 2 + k] !== 1'b1) bad_i++;
      acc = acc + mem_a[k];
    end
    chk({tag, "_payload_bad"}, 32'(bad_b), 32'd0);
    chk({tag, "_index_bad"}, 32'(bad_i), 32'd0);
    chk({tag, "_chk"}, 32'(rx_d[base + N + 2]), 32'(exp_chk));
    chk({tag, "_sum_zero"}, 32'(8'(acc + rx_d[base + N + 2])), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int lat, base, bd, br, bs;
    logic [7:0] acc;

    bus.i_TX_READY = 1'b1;
    for (int k = 0; k < 128; k++) begin
      mem_a[k] = 8'(k);
      mem_b[k] = 8'hEE;
    end

    // reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd", 32'(bus.o_R2_RD), 32'd0);
    chk("rst_idx", 32'(bus.o_R2_RD_INDEX), 32'd0);
    chk("rst_data", 32'(bus.o_TX_DATA), 32'd0);
    chk("rst_valid", 32'(bus.o_TX_VALID), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // RAM[i]=i, ready high
    base = rx_n; bd = done_n; br = rd_rise;
    run_frame(1'b0, 1'b0, lat);
    tick();
    check_frame("ramp", base, 8'h98);
    chk("ramp_latency", 32'(lat), 32'd145);
    chk("ramp_done_cnt", 32'(done_n - bd), 32'd1);
    chk("ramp_rd_rises", 32'(rd_rise - br), 32'd1);
    chk("ramp_idle_busy", 32'(busy), 32'd0);

    // all-zero RAM
    for (int k = 0; k < 128; k++) mem_a[k] = 8'h00;
    base = rx_n;
    run_frame(1'b0, 1'b0, lat);
    tick();
    check_frame("zero", base, 8'hD1);

    // random ready stalls
    for (int k = 0; k < 128; k++) mem_a[k] = 8'(k);
    base = rx_n; bs = stall_bad; br = rd_rise;
    run_frame(1'b1, 1'b0, lat);
    tick();
    check_frame("stall", base, 8'h98);
    chk("stall_hold", 32'(stall_bad - bs), 32'd0);
    chk("stall_rd_rises", 32'(rd_rise - br), 32'd1);

    // start pulsed while busy
    base = rx_n; bd = done_n;
    run_frame(1'b0, 1'b1, lat);
    repeat (20) tick();
    chk("poke_done_cnt", 32'(done_n - bd), 32'd1);
    chk("poke_bytes", 32'(rx_n - base), 32'(FRAMEB));
    chk("poke_busy", 32'(busy), 32'd0);

    // reset after payload byte 10
    base = rx_n; bd = done_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_rx(base + 13);
    rst_n = 1'b0;
    tick();
    chk("abort_valid", 32'(bus.o_TX_VALID), 32'd0);
    chk("abort_rd", 32'(bus.o_R2_RD), 32'd0);
    chk("abort_idx", 32'(bus.o_R2_RD_INDEX), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (20) tick();
    chk("abort_bytes", 32'(rx_n - base), 32'd13);
    chk("abort_no_done", 32'(done_n - bd), 32'd0);
    base = rx_n;
    run_frame(1'b0, 1'b0, lat);
    tick();
    check_frame("after_abort", base, 8'h98);

    // upstream copy request mid-frame
    acc = 8'h2F;
    for (int k = 0; k < 128; k++) begin
      mem_a[k] = 8'(k) ^ 8'h5A;
      mem_b[k] = 8'hFF - 8'(k);
    end
    for (int k = 0; k < N; k++) acc = acc + mem_a[k];
    base = rx_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_rx(base + 22);
    copy_req = 1'b1;
    tick();
    copy_req = 1'b0;
    chk("swap_deferred", 32'(bank_q), 32'd0);
    for (int k = 0; k < 1000 && done_n == 0; k++) tick();
    bd = done_n;
    for (int k = 0; k < 1000; k++) begin
      if (rx_n - base >= FRAMEB && busy == 1'b0) break;
      tick();
    end
    repeat (3) tick();
    check_frame("swap", base, 8'(~acc + 8'd1));
    chk("swap_bank", 32'(bank_q), 32'd1);
    chk("swap_when_rd_fell", 32'(swap_cyc), 32'(done_cyc - 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
